full_xor_nshr_pipe: RTL and testbench
=====================================

// Module: full_xor_nshr_pipe
// PURPOSE
//  Generic N-share Boolean unmasker: compresses N_SHARES K_WIDTH-bit XOR shares into one unmasked word.
//  Shares are refreshed by a log2 tree of fresh-random XOR pairs before the final fold.
//  Successor of the fixed 3-share unmasker. Adds any N, optional per-layer pipelining,
//  valid/ready flow control on both sides, a randomness handshake and a synchronous flush.
//  Sits at the tail of B2A/A2B share-conversion chains.
// PARAMETERS
//  K_WIDTH     32  bits per share
//  N_SHARES    3   share count, legal 2..16
//  PIPE_LAYERS 0   1: register after every refresh layer; 0: layers combinational
//  LAYERS      $clog2(N_SHARES)  refresh layers (derived, do not override)
//  RANDNUM     N_SHARES-1        random words per beat (derived)
//  DEPTH       2+PIPE_LAYERS*LAYERS  pipeline stages = latency (derived)
// PORTS
//  clk      in   1                  clock, rising edge
//  rst_n    in   1                  asynchronous active-low reset
//  ena      in   1                  global enable; 0 freezes every register
//  clr      in   1                  synchronous flush of all in-flight beats
//  i_x      in   K_WIDTH*N_SHARES   input shares, share j at [j*K_WIDTH +: K_WIDTH]
//  i_vld    in   1                  input beat valid
//  i_rdy    out  1                  input beat ready
//  rnd      in   K_WIDTH*RANDNUM    fresh randomness, word m at [m*K_WIDTH +: K_WIDTH]
//  rnd_vld  in   1                  randomness valid
//  rnd_ack  out  1                  randomness consumed this cycle
//  o_z      out  K_WIDTH            unmasked result
//  o_vld    out  1                  result valid
//  o_rdy    in   1                  downstream ready
//  o_busy   out  1                  OR of all stage valids
// BEHAVIOUR
//  Reset: all stage valids, o_vld, o_busy = 0. o_z and all data/random registers = 0.
//  Accept: acc = i_vld & rnd_vld & i_rdy. rnd_ack = acc. i_x and rnd are both captured into stage 0.
//  Stall chain: rdy_k = ena & (~vld_k | rdy_k+1). rdy_DEPTH = o_rdy. i_rdy = rdy_0.
//   i_rdy is combinational; i_vld/rnd_vld never depend on i_rdy.
//  Stage k loads when rdy_k is 1: vld_k <= vld_k-1 (vld_-1 = acc). Data moves with its valid.
//   A stage holding a valid beat is never overwritten while it is stalled.
//  Refresh layer l (0..LAYERS-1): for every j with j mod 2^(l+1)==0 and j+2^l<N_SHARES:
//   share j ^= r and share j+2^l ^= r.
//   r = rnd word index = running pair count, numbered layer-major then ascending j.
//   Total pairs = N_SHARES-1. Randomness travels with its beat until its layer is applied.
//  Final stage registers o_z = XOR of all refreshed shares. This equals XOR of the original shares.
//  Latency: o_vld rises DEPTH cycles after acc, given no stall. Throughput is 1 beat/cycle while o_rdy=1.
//  o_z and o_vld are held stable while o_vld=1 and o_rdy=0.
//  Ordering: beats leave in acceptance order; none is dropped or duplicated except by clr.
//  clr (only when ena=1): all vld_k <= 0 next edge. i_rdy = 0 and rnd_ack = 0 in the clr cycle.
//   Data registers are not required to clear.
//  ena=0: no register changes, i_rdy=0, rnd_ack=0. Outputs hold their last values. clr is ignored.
//  Reset mid-operation: all in-flight beats are lost. First accept possible in the first enabled cycle after rst_n rises.
//  o_busy = |vld_k (registered stage valids only).
// TESTING
//  1. N=3, K=8, PIPE=0: i_x={0F,3C,5A}, rnd={AA,55}, o_rdy=1 -> o_z=0x69, o_vld exactly 2 cycles after acc.
//  2. Same shares, 64 random rnd values -> o_z always 0x69.
//     rnd_vld=0 while i_vld=1 -> no acc, rnd_ack=0, o_vld stays 0.
//  3. N=4, PIPE=1 (DEPTH=4), o_rdy=0, stream 6 beats -> exactly 4 accepted, then i_rdy=0.
//     Raise o_rdy -> results in order at 1/cycle, o_busy falls after the last beat.
//  4. N=16, K=32, random shares/rnd, random o_rdy/i_vld/rnd_vld -> scoreboard matches XOR of shares, in order.
//  5. Beats in flight: pulse clr -> o_vld=0 next cycle, nothing emitted. Hold ena=0 for 3 cycles mid-stream -> all state frozen.
//  6. Assert rst_n=0 asynchronously mid-stream -> o_vld, o_busy, o_z = 0 immediately. Fresh beat after release -> correct result.

Source files
------------

// File: rtl/full_xor_nshr_pipe_if.sv
// rtl/full_xor_nshr_pipe_if.sv - share, randomness and result handshakes of the N-share unmasker
interface full_xor_nshr_pipe_if #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 3
);
  localparam int RANDNUM = N_SHARES - 1;

  logic [K_WIDTH*N_SHARES-1:0] i_x;
  logic                        i_vld;
  logic                        i_rdy;
  logic [K_WIDTH*RANDNUM-1:0]  rnd;
  logic                        rnd_vld;
  logic                        rnd_ack;
  logic [K_WIDTH-1:0]          o_z;
  logic                        o_vld;
  logic                        o_rdy;

  modport master (
    output i_x, i_vld, rnd, rnd_vld, o_rdy,
    input  i_rdy, rnd_ack, o_z, o_vld
  );

  modport slave (
    input  i_x, i_vld, rnd, rnd_vld, o_rdy,
    output i_rdy, rnd_ack, o_z, o_vld
  );
endinterface

// File: rtl/full_xor_nshr_pipe.sv
// rtl/full_xor_nshr_pipe.sv - N-share Boolean unmasker with randomness refresh tree
// Stage 0 captures shares+randomness, optional per-layer stages refresh, last stage folds to o_z.
module full_xor_nshr_pipe #(
  parameter int K_WIDTH     = 32,
  parameter int N_SHARES    = 3,
  parameter int PIPE_LAYERS = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 clr,
  full_xor_nshr_pipe_if.slave  bus,
  output logic                 o_busy
);
  localparam int LAYERS  = $clog2(N_SHARES);
  localparam int RANDNUM = N_SHARES - 1;
  localparam int DEPTH   = 2 + PIPE_LAYERS * LAYERS;
  localparam int NS      = DEPTH - 1;
  localparam int XW      = K_WIDTH * N_SHARES;
  localparam int RW      = K_WIDTH * RANDNUM;

  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [XW-1:0]      x_q [NS];
  logic [XW-1:0]      x_d [NS];
  logic [RW-1:0]      r_q [NS];
  logic [RW-1:0]      r_d [NS];
  logic [K_WIDTH-1:0] z_q, z_d;
  logic [DEPTH-1:0]   rdy;
  logic               acc;

  // Applies refresh layers lo..hi-1; the random word index keeps counting across skipped layers.
  function automatic logic [XW-1:0] refresh(input logic [XW-1:0] x, input logic [RW-1:0] rv,
                                            input int lo, input int hi);
    logic [XW-1:0] y;
    int            r;
    y = x;
    r = 0;
    for (int l = 0; l < LAYERS; l++) begin
      for (int j = 0; j < N_SHARES; j++) begin
        if (((j % (2 << l)) == 0) && ((j + (1 << l)) < N_SHARES)) begin
          if ((l >= lo) && (l < hi)) begin
            y[j*K_WIDTH +: K_WIDTH]              = y[j*K_WIDTH +: K_WIDTH] ^ rv[r*K_WIDTH +: K_WIDTH];
            y[(j + (1 << l))*K_WIDTH +: K_WIDTH] = y[(j + (1 << l))*K_WIDTH +: K_WIDTH] ^ rv[r*K_WIDTH +: K_WIDTH];
          end
          r++;
        end
      end
    end
    return y;
  endfunction

  function automatic logic [K_WIDTH-1:0] fold(input logic [XW-1:0] x);
    logic [K_WIDTH-1:0] z;
    z = '0;
    for (int j = 0; j < N_SHARES; j++) begin
      z = z ^ x[j*K_WIDTH +: K_WIDTH];
    end
    return z;
  endfunction

  // A stage may load when it is empty or everything downstream of it can move.
  always_comb begin : stall_chain
    logic c;
    c   = bus.o_rdy;
    rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      c      = ~vld_q[k] | c;
      rdy[k] = ena & c;
    end
  end

  assign bus.i_rdy   = rdy[0] & ~clr;
  assign acc         = bus.i_vld & bus.rnd_vld & bus.i_rdy;
  assign bus.rnd_ack = acc;
  assign bus.o_z     = z_q;
  assign bus.o_vld   = vld_q[DEPTH-1];
  assign o_busy      = |vld_q;

  always_comb begin
    vld_d = vld_q;
    x_d   = x_q;
    r_d   = r_q;
    z_d   = z_q;
    if (ena && clr) begin
      vld_d = '0;
    end else begin
      if (rdy[0]) vld_d[0] = acc;
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) vld_d[k] = vld_q[k-1];
      end
      if (acc) begin
        x_d[0] = bus.i_x;
        r_d[0] = bus.rnd;
      end
      for (int k = 1; k < NS; k++) begin
        if (rdy[k] && vld_q[k-1]) begin
          x_d[k] = refresh(x_q[k-1], r_q[k-1], k - 1, k);
          r_d[k] = r_q[k-1];
        end
      end
      // Without per-layer registers every layer is applied here in front of the fold.
      if (rdy[DEPTH-1] && vld_q[DEPTH-2]) begin
        z_d = fold(refresh(x_q[NS-1], r_q[NS-1], PIPE_LAYERS * LAYERS, LAYERS));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      z_q   <= '0;
      for (int k = 0; k < NS; k++) begin
        x_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      z_q   <= z_d;
      x_q   <= x_d;
      r_q   <= r_d;
    end
  end
endmodule

// File: tb/tb_full_xor_nshr_pipe.sv
// tb/tb_full_xor_nshr_pipe.sv - randomized scoreboard bench for the N-share unmasker
module tb_full_xor_nshr_pipe;
  localparam int K     = 16;
  localparam int N     = 5;
  localparam int P     = 1;
  localparam int RN    = N - 1;
  localparam int DEPTH = 2 + P * $clog2(N);

  logic clk = 1'b0;
  logic rst_n, ena, clr, o_busy;
  int   errors = 0;
  int   checks = 0;
  logic [K-1:0] exp_q [$];

  full_xor_nshr_pipe_if #(.K_WIDTH(K), .N_SHARES(N)) bus ();

  full_xor_nshr_pipe #(.K_WIDTH(K), .N_SHARES(N), .PIPE_LAYERS(P)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .bus(bus), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [K-1:0] ref_unmask(input logic [K*N-1:0] x);
    logic [K-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v = v ^ x[j*K +: K];
    return v;
  endfunction

  // Reference model and scoreboard: push at acceptance, pop when a result leaves.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      logic xfer_in;
      if (bus.o_vld && bus.o_rdy && ena && !clr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h with no beat outstanding", bus.o_z);
        end else begin
          chk("o_z", bus.o_z, exp_q.pop_front());
        end
      end
      if (ena && clr) exp_q.delete();
      xfer_in = bus.i_vld & bus.rnd_vld & bus.i_rdy;
      chk("rnd_ack", bus.rnd_ack, xfer_in);
      if (!ena || clr) chk("i_rdy_blocked", bus.i_rdy, 1'b0);
      if (xfer_in) exp_q.push_back(ref_unmask(bus.i_x));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_vld   = 1'b0;
    bus.rnd_vld = 1'b0;
  endtask

  task automatic rand_rnd();
    for (int m = 0; m < RN; m++) bus.rnd[m*K +: K] = K'($urandom);
  endtask

  task automatic rand_data();
    for (int j = 0; j < N; j++) bus.i_x[j*K +: K] = K'($urandom);
    rand_rnd();
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.o_rdy = 1'b1;
    while ((o_busy || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_done", (n < 200), 1'b1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.o_vld && n < 30) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, cnt, outs;
    logic [K-1:0] z_s;
    logic         v_s, b_s;
    rst_n = 1'b0; ena = 1'b1; clr = 1'b0; bus.o_rdy = 1'b1;
    bus.i_x = '0; bus.rnd = '0; idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o_vld", bus.o_vld, 1'b0);
    chk("reset_o_busy", o_busy, 1'b0);
    chk("reset_o_z", bus.o_z, '0);
    rst_n = 1'b1;
    step();
    chk("i_rdy_after_reset", bus.i_rdy, 1'b1);

    // Directed beat: value and latency.
    bus.i_x = {16'h1234, 16'h0F0F, 16'hA5A5, 16'h00FF, 16'h8001};
    rand_rnd();
    bus.i_vld = 1'b1; bus.rnd_vld = 1'b1;
    step();
    idle();
    n = 1;
    while (!bus.o_vld && n < 30) begin
      step();
      n++;
    end
    chk("latency", n, DEPTH);
    chk("directed_o_z", bus.o_z, 16'h3860);
    drain();

    // Same shares, many random masks, back to back.
    for (int i = 0; i < 32; i++) begin
      rand_rnd();
      bus.i_vld = 1'b1; bus.rnd_vld = 1'b1;
      step();
    end
    idle();
    drain();

    // Shares offered without randomness are never accepted.
    bus.i_vld = 1'b1; bus.rnd_vld = 1'b0;
    repeat (4) step();
    idle();
    chk("no_rnd_o_vld", bus.o_vld, 1'b0);
    chk("no_rnd_busy", o_busy, 1'b0);

    // Stalled output: the pipeline holds exactly DEPTH beats.
    bus.o_rdy = 1'b0;
    cnt = 0;
    rand_data();
    bus.i_vld = 1'b1; bus.rnd_vld = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      @(negedge clk);
      if (bus.i_rdy) cnt++;
      @(posedge clk);
      #1;
      rand_data();
    end
    chk("capacity", cnt, DEPTH);
    chk("full_i_rdy", bus.i_rdy, 1'b0);
    idle();
    bus.o_rdy = 1'b1;
    n = 0; outs = 0;
    while (o_busy && n < 50) begin
      @(negedge clk);
      if (bus.o_vld) outs++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_outputs", outs, DEPTH);
    chk("drain_cycles", n, DEPTH);

    // Random traffic on both sides.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      bus.i_vld   = ($urandom_range(3) != 0);
      bus.rnd_vld = ($urandom_range(3) != 0);
      bus.o_rdy   = ($urandom_range(2) != 0);
      step();
    end
    idle();
    drain();

    // Flush beats in flight.
    bus.o_rdy = 1'b0;
    rand_data();
    bus.i_vld = 1'b1; bus.rnd_vld = 1'b1;
    repeat (3) step();
    clr = 1'b1;
    rand_data();
    step();
    clr = 1'b0;
    idle();
    chk("clr_o_vld", bus.o_vld, 1'b0);
    chk("clr_o_busy", o_busy, 1'b0);
    bus.o_rdy = 1'b1;
    repeat (6) step();
    chk("clr_nothing_out", bus.o_vld, 1'b0);

    // Freeze mid-stream with ena low; clr must be ignored meanwhile.
    bus.o_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      bus.i_vld = 1'b1; bus.rnd_vld = 1'b1;
      step();
    end
    z_s = bus.o_z; v_s = bus.o_vld; b_s = o_busy;
    ena = 1'b0; clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step();
      chk("freeze_o_z", bus.o_z, z_s);
      chk("freeze_o_vld", bus.o_vld, v_s);
      chk("freeze_busy", o_busy, b_s);
    end
    ena = 1'b1; clr = 1'b0;
    idle();
    drain();

    // Asynchronous reset mid-stream, then a fresh beat.
    for (int i = 0; i < 4; i++) begin
      rand_data();
      bus.i_vld = 1'b1; bus.rnd_vld = 1'b1;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_o_vld", bus.o_vld, 1'b0);
    chk("async_rst_busy", o_busy, 1'b0);
    chk("async_rst_o_z", bus.o_z, '0);
    idle();
    step();
    rst_n = 1'b1;
    bus.i_x = {16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};
    rand_rnd();
    bus.i_vld = 1'b1; bus.rnd_vld = 1'b1;
    step();
    idle();
    wait_out(n);
    chk("post_reset_vld", bus.o_vld, 1'b1);
    chk("post_reset_o_z", bus.o_z, 16'h001F);
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
